// File: rtl/prach_ditfft3_sched.sv
// Triplet scheduler ahead of the radix-3 DIT butterfly: buffers a gappy sample
// stream and releases gapless, frame-aligned x0/x1/x2 groups with error flags.
module prach_ditfft3_sched #(
    parameter int FRAME_LEN  = 1536,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [17:0] din_dr,
    input  logic signed [17:0] din_di,
    input  logic               din_dv,
    input  logic               sync_in,
    input  logic               hold,
    input  logic               err_clr,
    output logic signed [17:0] dout_dr,
    output logic signed [17:0] dout_di,
    output logic               dout_dv,
    output logic               sync_out,
    output logic               busy,
    output logic               frame_err,
    output logic               ovf_err
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int FCW = $clog2(FRAME_LEN + 1);
    localparam int EW  = 37;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_S0, ST_S1, ST_S2} state_t;

    state_t             state_q, state_d;
    logic [EW-1:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [FCW-1:0]     fcnt_q, fcnt_d;
    logic signed [17:0] dout_dr_q, dout_dr_d;
    logic signed [17:0] dout_di_q, dout_di_d;
    logic               dout_dv_q, dout_dv_d;
    logic               sync_out_q, sync_out_d;
    logic               busy_q, busy_d;
    logic               frame_err_q, frame_err_d;
    logic               ovf_err_q, ovf_err_d;

    logic               wr_en;
    logic               ovf_set;
    logic               ferr_set;
    logic [1:0]         pop;
    logic [EW-1:0]      head;
    logic               tag1, tag2, tag3;

    // Entry layout is {sync tag, di, dr}; tags of the next three entries drive the look-ahead.
    assign head = mem_q[rd_ptr_q];
    assign tag1 = mem_q[rd_ptr_q + AW'(1)][EW-1];
    assign tag2 = mem_q[rd_ptr_q + AW'(2)][EW-1];
    assign tag3 = mem_q[rd_ptr_q + AW'(3)][EW-1];

    // Full check uses the count at cycle start; a same-cycle pop does not free a slot.
    assign wr_en   = din_dv && (count_q < CW'(FIFO_DEPTH));
    assign ovf_set = din_dv && !wr_en;

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        busy_d     = busy_q;
        dout_dr_d  = dout_dr_q;
        dout_di_d  = dout_di_q;
        dout_dv_d  = 1'b0;
        sync_out_d = 1'b0;
        pop        = 2'd0;
        ferr_set   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    if (head[EW-1]) begin
                        fcnt_d  = '0;
                        busy_d  = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        pop = 2'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (count_q >= CW'(3) && !hold) begin
                    if (tag1 || tag2) begin
                        pop      = tag1 ? 2'd1 : 2'd2;
                        ferr_set = 1'b1;
                        fcnt_d   = '0;
                    end else begin
                        if (head[EW-1] && fcnt_q != '0) begin
                            ferr_set = 1'b1;
                            fcnt_d   = '0;
                        end
                        state_d = ST_S0;
                    end
                end
            end
            ST_S0, ST_S1, ST_S2: begin
                pop        = 2'd1;
                dout_dr_d  = $signed(head[17:0]);
                dout_di_d  = $signed(head[35:18]);
                dout_dv_d  = 1'b1;
                sync_out_d = (state_q == ST_S0) && (fcnt_q == '0);
                fcnt_d     = fcnt_q + FCW'(1);
                if (state_q == ST_S0) begin
                    state_d = ST_S1;
                end else if (state_q == ST_S1) begin
                    state_d = ST_S2;
                end else if (fcnt_q + FCW'(1) == FCW'(FRAME_LEN)) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (count_q >= CW'(4) && !hold && !tag1 && !tag2 && !tag3) begin
                    // Next triplet already clean and complete behind the entry popped now.
                    state_d = ST_S0;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rd_ptr_d    = rd_ptr_q + AW'(pop);
        wr_ptr_d    = wr_ptr_q + AW'(wr_en);
        count_d     = count_q + CW'(wr_en) - CW'(pop);
        frame_err_d = ferr_set | (frame_err_q & ~err_clr);
        ovf_err_d   = ovf_set | (ovf_err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {sync_in, din_di, din_dr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            fcnt_q      <= '0;
            dout_dr_q   <= '0;
            dout_di_q   <= '0;
            dout_dv_q   <= 1'b0;
            sync_out_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            fcnt_q      <= fcnt_d;
            dout_dr_q   <= dout_dr_d;
            dout_di_q   <= dout_di_d;
            dout_dv_q   <= dout_dv_d;
            sync_out_q  <= sync_out_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign dout_dr   = dout_dr_q;
    assign dout_di   = dout_di_q;
    assign dout_dv   = dout_dv_q;
    assign sync_out  = sync_out_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_prach_ditfft3_sched.sv
// Bench for prach_ditfft3_sched with FRAME_LEN=6, FIFO_DEPTH=8: directed scenarios
// plus random streams compared against a sample-list model of the framing rules.
module tb_prach_ditfft3_sched;
    localparam int FL    = 6;
    localparam int DEPTH = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [17:0] din_dr = '0;
    logic signed [17:0] din_di = '0;
    logic               din_dv = 1'b0;
    logic               sync_in = 1'b0;
    logic               hold = 1'b0;
    logic               err_clr = 1'b0;
    logic signed [17:0] dout_dr, dout_di;
    logic               dout_dv, sync_out, busy, frame_err, ovf_err;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    prach_ditfft3_sched #(.FRAME_LEN(FL), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
        .sync_in(sync_in), .hold(hold), .err_clr(err_clr), .dout_dr(dout_dr),
        .dout_di(dout_di), .dout_dv(dout_dv), .sync_out(sync_out), .busy(busy),
        .frame_err(frame_err), .ovf_err(ovf_err)
    );

    int n_pass = 0;
    int n_total = 0;

    logic signed [17:0] mon_dr[$], mon_di[$];
    bit                 mon_sy[$], mon_busy[$];
    int                 mon_cyc[$], runs[$];
    int                 run = 0;

    logic signed [17:0] st_dr[$], st_di[$];
    bit                 st_sy[$];
    logic signed [17:0] ex_dr[$], ex_di[$];
    bit                 ex_sy[$];
    bit                 ex_ferr;

    always @(negedge clk) begin
        if (dout_dv === 1'b1) begin
            mon_dr.push_back(dout_dr);
            mon_di.push_back(dout_di);
            mon_sy.push_back(sync_out);
            mon_busy.push_back(busy);
            mon_cyc.push_back(cyc);
            run = run + 1;
        end else begin
            if (run > 0) runs.push_back(run);
            run = 0;
        end
    end

    task automatic clear_mon();
        mon_dr.delete(); mon_di.delete(); mon_sy.delete(); mon_busy.delete();
        mon_cyc.delete(); runs.delete(); run = 0;
    endtask

    task automatic clear_stim();
        st_dr.delete(); st_di.delete(); st_sy.delete();
    endtask

    task automatic push_stim(input logic signed [17:0] v, input bit sy);
        st_dr.push_back(v);
        st_di.push_back(-v);
        st_sy.push_back(sy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; din_dv = 1'b0; sync_in = 1'b0; hold = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
    endtask

    // Presents the stimulus list; alt forces one idle cycle between samples.
    task automatic drive_stim(input int gap_pct, input bit alt, output int third_cyc);
        third_cyc = 0;
        for (int i = 0; i < st_dr.size(); i++) begin
            if (alt && i > 0) begin
                @(negedge clk); din_dv = 1'b0; sync_in = 1'b0;
            end
            while ($urandom_range(0, 99) < gap_pct) begin
                @(negedge clk); din_dv = 1'b0; sync_in = 1'b0;
            end
            @(negedge clk);
            din_dr = st_dr[i]; din_di = st_di[i]; din_dv = 1'b1; sync_in = st_sy[i];
            if (i == 2) third_cyc = cyc;
        end
        @(negedge clk);
        din_dv = 1'b0; sync_in = 1'b0;
    endtask

    // Walks the accepted sample list: skip to a tagged sample, emit groups of three,
    // abort on a tag inside a group, restart on a tag leading a group mid-frame.
    task automatic run_model();
        int i, fcnt, n;
        bit in_frame, done;
        ex_dr.delete(); ex_di.delete(); ex_sy.delete();
        ex_ferr = 1'b0; i = 0; fcnt = 0; n = st_dr.size(); in_frame = 1'b0; done = 1'b0;
        while (!done) begin
            if (!in_frame) begin
                if (i >= n) done = 1'b1;
                else if (st_sy[i]) begin in_frame = 1'b1; fcnt = 0; end
                else i++;
            end else if (n - i < 3) begin
                done = 1'b1;
            end else if (st_sy[i+1] || st_sy[i+2]) begin
                i += st_sy[i+1] ? 1 : 2;
                ex_ferr = 1'b1; fcnt = 0;
            end else begin
                if (st_sy[i] && fcnt != 0) begin ex_ferr = 1'b1; fcnt = 0; end
                for (int k = 0; k < 3; k++) begin
                    ex_dr.push_back(st_dr[i+k]);
                    ex_di.push_back(st_di[i+k]);
                    ex_sy.push_back(fcnt == 0 && k == 0);
                end
                fcnt += 3; i += 3;
                if (fcnt == FL) in_frame = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        logic [40:0] obs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        obs = {dout_dr, dout_di, dout_dv, sync_out, busy, frame_err, ovf_err};
        n_total++; if (dout_dv !== 1'b0) $display("FAIL reset_dv: got %b want 0", dout_dv); else n_pass++;
        n_total++; if (sync_out !== 1'b0) $display("FAIL reset_sync: got %b want 0", sync_out); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else n_pass++;
        n_total++; if (ovf_err !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf_err); else n_pass++;
        n_total++; if (obs !== 41'd0) $display("FAIL reset_all: got %h want 0", obs); else n_pass++;
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic test_gapless();
        int third;
        do_reset(); clear_stim();
        for (int v = 1; v <= 6; v++) push_stim(18'(v), v == 1);
        drive_stim(0, 1'b0, third);
        repeat (12) @(negedge clk);
        n_total++; if (mon_dr.size() !== 6) $display("FAIL gapless_count: got %0d want 6", mon_dr.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (i >= mon_dr.size() || mon_dr[i] !== 18'(i + 1) || mon_di[i] !== -18'(i + 1) || mon_sy[i] !== (i == 0))
                $display("FAIL gapless_sample%0d: got dr=%0d di=%0d sy=%0b want dr=%0d di=%0d sy=%0b", i,
                         (i < mon_dr.size()) ? mon_dr[i] : 0, (i < mon_di.size()) ? mon_di[i] : 0,
                         (i < mon_sy.size()) ? mon_sy[i] : 1'b0, i + 1, -(i + 1), i == 0);
            else n_pass++;
        end
        n_total++; if (runs.size() !== 1 || runs[0] !== 6) $display("FAIL gapless_run: got %0d runs first %0d want 1 run of 6", runs.size(), (runs.size() > 0) ? runs[0] : 0); else n_pass++;
        n_total++; if (mon_cyc.size() == 0 || mon_cyc[0] - third !== 3) $display("FAIL gapless_latency: got %0d want 3 edges after drive", (mon_cyc.size() > 0) ? mon_cyc[0] - third : -1); else n_pass++;
        n_total++; if (mon_busy.size() < 5 || mon_busy[4] !== 1'b1) $display("FAIL gapless_busy_open: got %0b want 1", (mon_busy.size() > 4) ? mon_busy[4] : 1'b0); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL gapless_busy_end: got %b want 0", busy); else n_pass++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL gapless_ferr: got %b want 0", frame_err); else n_pass++;
    endtask

    task automatic test_gaps();
        int third;
        do_reset(); clear_stim();
        for (int v = 1; v <= 6; v++) push_stim(18'(v), v == 1);
        drive_stim(0, 1'b1, third);
        repeat (12) @(negedge clk);
        n_total++; if (mon_dr.size() !== 6) $display("FAIL gaps_count: got %0d want 6", mon_dr.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (i >= mon_dr.size() || mon_dr[i] !== 18'(i + 1))
                $display("FAIL gaps_sample%0d: got %0d want %0d", i, (i < mon_dr.size()) ? mon_dr[i] : 0, i + 1);
            else n_pass++;
        end
        n_total++; if (runs.size() !== 2 || runs[0] !== 3 || runs[1] !== 3) $display("FAIL gaps_runs: got %0d runs want 2 runs of 3", runs.size()); else n_pass++;
    endtask

    task automatic test_early_sync();
        int third;
        int exp_v[9] = '{1, 2, 3, 5, 6, 7, 8, 9, 10};
        do_reset(); clear_stim();
        for (int v = 1; v <= 10; v++) push_stim(18'(v), v == 1 || v == 5);
        drive_stim(0, 1'b0, third);
        repeat (15) @(negedge clk);
        n_total++; if (mon_dr.size() !== 9) $display("FAIL early_count: got %0d want 9", mon_dr.size()); else n_pass++;
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (i >= mon_dr.size() || mon_dr[i] !== 18'(exp_v[i]) || mon_sy[i] !== (i == 0 || i == 3))
                $display("FAIL early_sample%0d: got %0d want %0d", i, (i < mon_dr.size()) ? mon_dr[i] : 0, exp_v[i]);
            else n_pass++;
        end
        n_total++; if (frame_err !== 1'b1) $display("FAIL early_ferr: got %b want 1", frame_err); else n_pass++;
        n_total++; if (ovf_err !== 1'b0) $display("FAIL early_ovf: got %b want 0", ovf_err); else n_pass++;
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        n_total++; if (frame_err !== 1'b0) $display("FAIL early_ferr_clr: got %b want 0", frame_err); else n_pass++;
    endtask

    task automatic test_garbage();
        int third;
        do_reset(); clear_stim();
        push_stim(18'sd7, 1'b0); push_stim(18'sd8, 1'b0);
        for (int v = 1; v <= 6; v++) push_stim(18'(v), v == 1);
        drive_stim(0, 1'b0, third);
        repeat (14) @(negedge clk);
        n_total++; if (mon_dr.size() !== 6) $display("FAIL garbage_count: got %0d want 6", mon_dr.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (i >= mon_dr.size() || mon_dr[i] !== 18'(i + 1) || mon_sy[i] !== (i == 0))
                $display("FAIL garbage_sample%0d: got %0d want %0d", i, (i < mon_dr.size()) ? mon_dr[i] : 0, i + 1);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        hold = 1'b1;
        for (int v = 1; v <= 10; v++) begin
            @(negedge clk);
            din_dr = 18'(v); din_di = -18'(v); din_dv = 1'b1; sync_in = (v == 1);
            err_clr = (v == 10);
        end
        @(negedge clk);
        din_dv = 1'b0; sync_in = 1'b0; err_clr = 1'b0;
        n_total++; if (ovf_err !== 1'b1) $display("FAIL ovf_set_wins: got %b want 1", ovf_err); else n_pass++;
        repeat (5) @(negedge clk);
        n_total++; if (mon_dr.size() !== 0) $display("FAIL ovf_hold_quiet: got %0d outputs want 0", mon_dr.size()); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL ovf_busy: got %b want 1", busy); else n_pass++;
        hold = 1'b0;
        repeat (20) @(negedge clk);
        n_total++; if (mon_dr.size() !== 6) $display("FAIL ovf_count: got %0d want 6", mon_dr.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (i >= mon_dr.size() || mon_dr[i] !== 18'(i + 1) || mon_sy[i] !== (i == 0))
                $display("FAIL ovf_sample%0d: got %0d want %0d", i, (i < mon_dr.size()) ? mon_dr[i] : 0, i + 1);
            else n_pass++;
        end
        n_total++; if (ovf_err !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf_err); else n_pass++;
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        n_total++; if (ovf_err !== 1'b0) $display("FAIL ovf_clr: got %b want 0", ovf_err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int  third;
        bit  seen;
        do_reset(); clear_stim();
        for (int v = 1; v <= 6; v++) push_stim(18'(v), v == 1);
        seen = 1'b0;
        fork
            drive_stim(0, 1'b0, third);
            begin
                for (int k = 0; k < 40 && !seen; k++) begin
                    @(negedge clk);
                    if (dout_dv === 1'b1) seen = 1'b1;
                end
                n_total++; if (!seen) $display("FAIL rstmid_trigger: got no output want output within 40 cycles"); else n_pass++;
                if (seen) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    n_total++;
                    if ({dout_dr, dout_di, dout_dv, sync_out, busy, frame_err, ovf_err} !== 41'd0)
                        $display("FAIL rstmid_outputs: got %h want 0", {dout_dr, dout_di, dout_dv, sync_out, busy, frame_err, ovf_err});
                    else n_pass++;
                end
            end
        join
        clear_mon(); clear_stim();
        for (int v = 11; v <= 16; v++) push_stim(18'(v), v == 11);
        drive_stim(0, 1'b0, third);
        repeat (14) @(negedge clk);
        n_total++; if (mon_dr.size() !== 6) $display("FAIL rstmid_count: got %0d want 6", mon_dr.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (i >= mon_dr.size() || mon_dr[i] !== 18'(i + 11) || mon_sy[i] !== (i == 0))
                $display("FAIL rstmid_sample%0d: got %0d want %0d", i, (i < mon_dr.size()) ? mon_dr[i] : 0, i + 11);
            else n_pass++;
        end
    endtask

    task automatic test_random(input int iters);
        int third, len, bad, bad_run;
        for (int it = 0; it < iters; it++) begin
            do_reset(); clear_stim();
            for (int s = 0; s < 8; s++) begin
                case ($urandom_range(0, 3))
                    0: begin
                        len = $urandom_range(1, 3);
                        for (int j = 0; j < len; j++) push_stim(18'($urandom), 1'b0);
                    end
                    3: begin
                        len = $urandom_range(1, 5);
                        for (int j = 0; j < len; j++) push_stim(18'($urandom), j == 0);
                    end
                    default: for (int j = 0; j < FL; j++) push_stim(18'($urandom), j == 0);
                endcase
            end
            run_model();
            drive_stim(50, 1'b0, third);
            repeat (40) @(negedge clk);
            n_total++; if (mon_dr.size() !== ex_dr.size()) $display("FAIL rand%0d_count: got %0d want %0d", it, mon_dr.size(), ex_dr.size()); else n_pass++;
            bad = -1;
            for (int i = 0; i < ex_dr.size() && bad < 0; i++)
                if (i >= mon_dr.size() || mon_dr[i] !== ex_dr[i] || mon_di[i] !== ex_di[i] || mon_sy[i] !== ex_sy[i]) bad = i;
            n_total++; if (bad >= 0) $display("FAIL rand%0d_data: first bad index %0d got dr=%0d want dr=%0d", it, bad, (bad < mon_dr.size()) ? mon_dr[bad] : 0, ex_dr[bad]); else n_pass++;
            n_total++; if (frame_err !== ex_ferr) $display("FAIL rand%0d_ferr: got %b want %b", it, frame_err, ex_ferr); else n_pass++;
            n_total++; if (ovf_err !== 1'b0) $display("FAIL rand%0d_ovf: got %b want 0", it, ovf_err); else n_pass++;
            bad_run = 0;
            foreach (runs[r]) if (runs[r] % 3 != 0) bad_run = runs[r];
            n_total++; if (bad_run != 0) $display("FAIL rand%0d_runlen: got run of %0d want multiple of 3", it, bad_run); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_gapless();
        test_gaps();
        test_early_sync();
        test_garbage();
        test_overflow();
        test_reset_mid();
        test_random(5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion want finish before 200000");
        $fatal(1);
    end

endmodule
